// File: rtl/msrv32_integer_file_sb.sv
// Parametrised integer register file with same-cycle write bypass and a
// per-register pending scoreboard whose occupancy is tracked by a counter.
module msrv32_integer_file_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_n_in,
  input  logic [AW-1:0]   rs_1_addr_in,
  input  logic [AW-1:0]   rs_2_addr_in,
  output logic [XLEN-1:0] rs_1_out,
  output logic [XLEN-1:0] rs_2_out,
  output logic            rs_1_busy_out,
  output logic            rs_2_busy_out,
  input  logic            wr_en_in,
  input  logic [AW-1:0]   rd_addr_in,
  input  logic [XLEN-1:0] rd_in,
  input  logic            issue_en_in,
  input  logic [AW-1:0]   issue_rd_addr_in,
  output logic [AW:0]     pending_cnt_out
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_nxt;
  logic             wr_ok;
  logic             iss_ok;
  logic             cnt_inc;
  logic             cnt_dec;

  assign wr_ok  = wr_en_in    && !(ZERO_REG && rd_addr_in == '0);
  assign iss_ok = issue_en_in && !(ZERO_REG && issue_rd_addr_in == '0);

  // Issue wins over write on the same address, so a write only frees a
  // pending entry when it is not being re-reserved in the same cycle.
  assign cnt_inc = iss_ok && !pending[issue_rd_addr_in];
  assign cnt_dec = wr_ok && pending[rd_addr_in] &&
                   !(iss_ok && issue_rd_addr_in == rd_addr_in);

  always_comb begin
    pending_nxt = pending;
    if (wr_ok)
      pending_nxt[rd_addr_in] = 1'b0;
    if (iss_ok)
      pending_nxt[issue_rd_addr_in] = 1'b1;
  end

  assign cnt_nxt = cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      pending <= '0;
      cnt     <= '0;
    end else begin
      if (wr_ok)
        regs[rd_addr_in] <= rd_in;
      pending <= pending_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign pending_cnt_out = cnt;

  always_comb begin
    rs_1_out      = regs[rs_1_addr_in];
    rs_1_busy_out = pending[rs_1_addr_in];
    if (ZERO_REG && rs_1_addr_in == '0) begin
      rs_1_out      = '0;
      rs_1_busy_out = 1'b0;
    end else if (BYPASS && wr_en_in && rd_addr_in == rs_1_addr_in) begin
      rs_1_out      = rd_in;
      rs_1_busy_out = 1'b0;
    end
  end

  always_comb begin
    rs_2_out      = regs[rs_2_addr_in];
    rs_2_busy_out = pending[rs_2_addr_in];
    if (ZERO_REG && rs_2_addr_in == '0) begin
      rs_2_out      = '0;
      rs_2_busy_out = 1'b0;
    end else if (BYPASS && wr_en_in && rd_addr_in == rs_2_addr_in) begin
      rs_2_out      = rd_in;
      rs_2_busy_out = 1'b0;
    end
  end

endmodule
